// File: rtl/hpu_job_sched.sv
// Job sequencer for the HPU datapath: runs item generation, a settle gap, then the stream run.
// Optional HPU_JOB_WDOG_EN adds a RUN-phase inactivity watchdog with a sticky timeout output.
module hpu_job_sched #(
  parameter int NUM_W   = 16,
  parameter int GAP_CYC = 2,
  parameter int WDOG_W  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             clr_done,
  input  logic [NUM_W-1:0] item_num,
  input  logic             get_fin,
  input  logic             get_v,
  input  logic             dst_valid,
  input  logic             dst_ready,
  input  logic             dst_last,
  output logic             gen,
  output logic             run,
  output logic [NUM_W-1:0] item_a,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [2:0]       phase,
`ifdef HPU_JOB_WDOG_EN
  output logic             timeout,
`endif
  output logic [31:0]      cycles
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GEN  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  if (GAP_CYC < 1 || GAP_CYC > 15 || WDOG_W < 2) begin : g_param_check
    $error("hpu_job_sched: parameter out of range");
  end

  logic [2:0]       state;
  logic [NUM_W-1:0] num_q;
  logic [3:0]       gap_cnt;
  logic             fin_seen;
  logic             last_seen;
  logic             hs;
  logic             fin_now;
  logic             last_now;
  logic             accept;
  logic             kill;

  assign hs       = dst_valid & dst_ready;
  assign fin_now  = fin_seen | get_fin;
  assign last_now = last_seen | (hs & dst_last);
  assign accept   = (state == S_IDLE) & start;
  assign phase    = state;

`ifdef HPU_JOB_WDOG_EN
  logic [WDOG_W-1:0] wdog;
  logic              wd_hit;

  assign wd_hit = (state == S_RUN) & (&wdog);
  assign kill   = ((state != S_IDLE) & abort) | wd_hit;

  // Any beat on either side of the datapath counts as forward progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      if (state != S_RUN || hs || get_v) wdog <= '0;
      else                               wdog <= wdog + 1'b1;
      if (accept)        timeout <= 1'b0;
      else if (wd_hit)   timeout <= 1'b1;
      else if (clr_done) timeout <= 1'b0;
    end
  end
`else
  logic unused_in;
  assign unused_in = get_v;
  assign kill      = (state != S_IDLE) & abort;
`endif

  always_ff @(posedge clk) begin
    if (accept) num_q <= item_num;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      gen       <= 1'b0;
      run       <= 1'b0;
      item_a    <= '0;
      busy      <= 1'b0;
      gap_cnt   <= '0;
      fin_seen  <= 1'b0;
      last_seen <= 1'b0;
    end else if (kill) begin
      state  <= S_IDLE;
      gen    <= 1'b0;
      run    <= 1'b0;
      item_a <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state  <= S_GEN;
          gen    <= 1'b1;
          item_a <= '0;
          busy   <= 1'b1;
        end
        // Compare before increment so an all-ones count never wraps item_a.
        S_GEN: if (item_a == num_q) begin
          gen     <= 1'b0;
          item_a  <= '0;
          gap_cnt <= '0;
          state   <= S_GAP;
        end else begin
          item_a <= item_a + 1'b1;
        end
        S_GAP: if (gap_cnt == GAP_LAST) begin
          run       <= 1'b1;
          fin_seen  <= 1'b0;
          last_seen <= 1'b0;
          state     <= S_RUN;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        S_RUN: begin
          fin_seen  <= fin_now;
          last_seen <= last_now;
          if (fin_now && last_now) begin
            run   <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky status: a same-cycle set beats clr_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= 1'b0;
      aborted <= 1'b0;
      cycles  <= '0;
    end else if (accept) begin
      done    <= 1'b0;
      aborted <= 1'b0;
      cycles  <= '0;
    end else begin
      if (busy && cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
      if (kill)          aborted <= 1'b1;
      else if (clr_done) aborted <= 1'b0;
      if (state == S_DONE && !kill) done <= 1'b1;
      else if (clr_done)            done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hpu_job_sched.sv
// Randomized self-checking bench for hpu_job_sched; expected timing is derived per job from the
// documented phase lengths (gen = num+1 cycles, GAP_CYC gap, retirement on the later of fin/TLAST).
module tb_hpu_job_sched;
  localparam int NUM_W   = 16;
  localparam int GAP_CYC = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort, clr_done;
  logic [NUM_W-1:0] item_num;
  logic             get_fin, get_v, dst_valid, dst_ready, dst_last;
  logic             gen, run, busy, done, aborted;
  logic [NUM_W-1:0] item_a;
  logic [2:0]       phase;
  logic [31:0]      cycles;
`ifdef HPU_JOB_WDOG_EN
  logic             timeout;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hpu_job_sched #(.NUM_W(NUM_W), .GAP_CYC(GAP_CYC), .WDOG_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .clr_done(clr_done),
    .item_num(item_num), .get_fin(get_fin), .get_v(get_v),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_last(dst_last),
    .gen(gen), .run(run), .item_a(item_a), .busy(busy), .done(done),
    .aborted(aborted), .phase(phase),
`ifdef HPU_JOB_WDOG_EN
    .timeout(timeout),
`endif
    .cycles(cycles)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; clr_done = 0; get_fin = 0; get_v = 0;
    dst_valid = 0; dst_ready = 0; dst_last = 0;
  endtask

  // One job. f/l: RUN cycle (1 = first RUN cycle) of the get_fin pulse / TLAST handshake.
  // ab: clock edge (counted from the start edge = 1) at which abort is sampled, -1 for none.
  task automatic do_job(input logic [NUM_W-1:0] num, input int f, input int l, input int ab,
                        input bit noise, input bit coll);
    int r, d, lim, gen_cnt, run_cnt, run_rise, done_edge, done_rises, stop_noise;
    logic [NUM_W-1:0] exp_a;
    bit seq_ok, prev_done;
    r = int'(num) + 2 + GAP_CYC;
    d = r + ((f > l) ? f : l);
    lim = (ab >= 0) ? ab + 3 : d + 4;
    stop_noise = (ab >= 0 && ab - 1 < d) ? ab - 1 : d;
    gen_cnt = 0; run_cnt = 0; run_rise = -1; done_edge = -1; done_rises = 0;
    exp_a = '0; seq_ok = 1;
    @(negedge clk);
    idle_inputs();
    start = 1; item_num = num;
    prev_done = done;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      idle_inputs();
      if (gen) begin
        gen_cnt++;
        if (item_a !== exp_a) seq_ok = 0;
        exp_a = exp_a + 1'b1;
      end
      if (run) run_cnt++;
      if (run && run_rise < 0) run_rise = k;
      if (done && !prev_done) begin
        done_rises++;
        if (done_edge < 0) done_edge = k;
      end
      prev_done = done;
      if (k == 1) begin
        check_eq("accept_busy", busy, 1);
        check_eq("accept_phase", phase, 1);
        check_eq("accept_cycles", cycles, 0);
      end
      if (ab >= 0 && k == ab) begin
        check_eq("abort_gen", gen, 0);
        check_eq("abort_run", run, 0);
        check_eq("abort_flag", aborted, 1);
        check_eq("abort_done", done, 0);
        check_eq("abort_item_a", item_a, 0);
      end
      if (noise && k + 1 <= stop_noise) begin
        start = 1'($urandom_range(0, 1));
        item_num = NUM_W'($urandom);
        dst_valid = 1'($urandom_range(0, 1));
        dst_ready = 1'($urandom_range(0, 1));
        if (k + 1 <= r) begin
          get_fin  = 1'($urandom_range(0, 1));
          dst_last = 1'($urandom_range(0, 1));
        end
      end
      if (k + 1 == r + f) get_fin = 1;
      if (k + 1 == r + l) begin
        dst_valid = 1; dst_ready = 1; dst_last = 1;
      end
      if (coll && k + 1 == d + 1) clr_done = 1;
      if (k + 1 == ab) abort = 1;
    end
    if (ab < 0) begin
      check_eq("gen_cycles", gen_cnt, int'(num) + 1);
      check_eq("item_a_seq", seq_ok, 1);
      check_eq("run_rise", run_rise, r);
      check_eq("run_len", run_cnt, d - r);
      check_eq("done_edge", done_edge, d + 1);
      check_eq("done_once", done_rises, 1);
      check_eq("done_hold", done, 1);
      check_eq("cycles", cycles, d);
      check_eq("end_busy", busy, 0);
      check_eq("end_aborted", aborted, 0);
      check_eq("end_phase", phase, 0);
    end else begin
      check_eq("abort_busy", busy, 0);
      check_eq("abort_phase", phase, 0);
      check_eq("abort_cycles", cycles, ab - 1);
      check_eq("abort_no_done", done_rises, 0);
    end
  endtask

  initial begin
    int f, l, ab, n;
    idle_inputs();
    item_num = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    check_eq("rst_gen", gen, 0);
    check_eq("rst_run", run, 0);
    check_eq("rst_item_a", item_a, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_aborted", aborted, 0);
    check_eq("rst_phase", phase, 0);
    check_eq("rst_cycles", cycles, 0);
    rst = 0;

    do_job(16'd7, 20, 25, -1, 0, 0);
    @(negedge clk); clr_done = 1;
    @(negedge clk); clr_done = 0;
    check_eq("clr_done", done, 0);
    do_job(16'd5, 12, 4, -1, 0, 0);
    do_job(16'd3, 9, 9, -1, 0, 0);
    do_job(16'd7, 30, 30, 5, 0, 0);
    do_job(16'd2, 40, 40, 12, 0, 0);
    do_job(16'd4, 6, 6, 14, 0, 0);
    do_job(16'd6, 10, 3, -1, 1, 1);
    do_job(16'd0, 1, 1, -1, 0, 0);

    for (int j = 0; j < 24; j++) begin
      n  = $urandom_range(0, 40);
      f  = $urandom_range(1, 30);
      l  = $urandom_range(1, 30);
      ab = -1;
      if (j % 4 == 3) ab = $urandom_range(2, n + 2 + GAP_CYC + ((f > l) ? f : l));
      do_job(NUM_W'(n), f, l, ab, 1, 1'($urandom_range(0, 1)));
    end

    do_job(16'hFFFF, 2, 3, -1, 0, 0);

    @(negedge clk); start = 1; item_num = 16'd10;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk); rst = 0;
    check_eq("midrst_gen", gen, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_item_a", item_a, 0);
    check_eq("midrst_cycles", cycles, 0);

`ifdef HPU_JOB_WDOG_EN
    begin
      int to_edge;
      to_edge = -1;
      @(negedge clk); start = 1; item_num = '0;
      for (int k = 1; k <= 300; k++) begin
        @(negedge clk); idle_inputs();
        if (aborted && to_edge < 0) to_edge = k;
      end
      check_eq("wdog_edge", to_edge, 2 + GAP_CYC + 256);
      check_eq("wdog_timeout", timeout, 1);
      check_eq("wdog_run", run, 0);
      @(negedge clk); start = 1; item_num = '0;
      for (int k = 1; k <= 600; k++) begin
        @(negedge clk); idle_inputs();
        get_v = (k % 100 == 0);
      end
      check_eq("wdog_quiet_timeout", timeout, 0);
      check_eq("wdog_quiet_run", run, 1);
      abort = 1;
      @(negedge clk); idle_inputs();
      check_eq("wdog_quiet_abort", aborted, 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hpu_job_sched.md
Name: hpu_job_sched

Overview:
- Job sequencer for the HPU datapath. Replaces manual software toggling of the gen/run register bits.
- A single start command triggers two phases in order: item-memory generation (drives gen and the item address counter into core/xorshift), then the stream run (drives run into get_enable/get_ctrl/buffer_ctrl/stream_ctrl).
- The job retires only after input get_fin and the output TLAST handshake have both been observed.
- Sits between the AXI-Lite register file (start/abort/status) and the AXIS-clocked datapath.

Parameters:
- NUM_W, 16, width of item count and item address.
- GAP_CYC, 2, idle settle cycles between gen phase end and run assertion (1..15).
- WDOG_W, 20, watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  AXIS clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle job start request
- abort  in  1  single-cycle job abort request
- clr_done  in  1  clears the done and aborted flags
- item_num  in  NUM_W  last item index to generate; sampled on accepted start
- get_fin  in  1  pulse from get_ctrl: all input beats consumed
- get_v  in  1  input beat accepted (activity indicator)
- dst_valid  in  1  M_AXIS_TVALID
- dst_ready  in  1  M_AXIS_TREADY
- dst_last  in  1  M_AXIS_TLAST
- gen  out  1  generation phase enable
- run  out  1  run phase enable
- item_a  out  NUM_W  item memory write address
- busy  out  1  job in progress
- done  out  1  sticky job-complete flag
- aborted  out  1  sticky abort flag
- phase  out  3  encoded state, for status readback
- cycles  out  32  job cycle count, saturating

Behaviour:
- Reset: state IDLE; gen=0, run=0, item_a=0, busy=0, done=0, aborted=0, cycles=0, phase=0. All outputs are registered.
- States and phase codes: IDLE=0, GEN=1, GAP=2, RUN=3, DONE=4.
- IDLE:
  - start accepted → GEN next cycle.
  - On acceptance: latch item_num into num_q, clear done/aborted, cycles=0, busy=1.
- GEN:
  - gen=1; item_a starts at 0 and increments by 1 each cycle.
  - When item_a==num_q: gen<=0, item_a<=0, go GAP.
  - gen is therefore high for num_q+1 cycles, presenting item_a values 0..num_q.
  - num_q=0 gives exactly one gen cycle.
- GAP: gen=run=0 for GAP_CYC cycles, then run<=1 and go RUN.
- RUN:
  - run=1. Two sticky flags: fin_seen (set on get_fin) and last_seen (set on dst_valid&dst_ready&dst_last).
  - Both flags are monitored from RUN entry. If the same-cycle event occurs, set both.
  - When both flags are set (including the cycle they become set): run<=0, go DONE.
- DONE: one cycle; done<=1, busy<=0, return to IDLE.
- done: holds until clr_done or the next accepted start. clr_done in the same cycle as done being set: set wins.
- cycles:
  - Increments each cycle while busy, from the cycle after start acceptance through the DONE cycle.
  - Saturates at 32'hFFFFFFFF.
  - Holds its value in IDLE.
- start while busy: ignored, with no side effects.
- abort:
  - In any non-IDLE state: next cycle state IDLE, gen=0, run=0, item_a=0, busy=0, aborted=1, done unchanged.
  - abort has priority over start and over a same-cycle completion.
  - abort in IDLE is ignored.
- Downstream blocks reset on ~run, so abort also flushes them.
- rst mid-job: immediate return to reset values on the next edge.
- item_a wraps naturally at 2^NUM_W only if num_q = all ones. The GEN exit compare happens first, so no wrap actually occurs.

Optional Feature:
- Macro: HPU_JOB_WDOG_EN.
- Enabled:
  - A WDOG_W-bit counter runs in RUN. It clears on any get_v or dst_valid&dst_ready cycle and on RUN entry; otherwise it increments.
  - On reaching all ones, act as abort, and additionally assert sticky output timeout (extra 1-bit port). timeout is cleared by clr_done or an accepted start.
- Disabled: no counter; the timeout port is absent. RUN waits indefinitely.

Test Plan:
- item_num=7, start; get_fin pulse at cycle 20 of RUN; TLAST handshake 5 cycles later → gen high for 8 cycles with item_a 0..7, run rises GAP_CYC=2 cycles after gen falls, done=1 one cycle after the handshake, cycles equals the exact elapsed count.
- TLAST handshake before get_fin, and a separate case with both in the same cycle → retirement on the later (or the same) cycle; done asserted exactly once.
- abort during GEN at item_a=3, and separately during RUN → gen/run=0 next cycle, aborted=1, done=0; a new start then runs a full job cleanly.
- start pulses while busy, plus clr_done colliding with done being set → no restart and item_num not relatched; done ends at 1.
- item_num=0 and item_num=16'hFFFF → 1 and 65536 gen cycles respectively; no item_a wrap; transition to GAP.
- With HPU_JOB_WDOG_EN and WDOG_W=8: stall with no activity in RUN → timeout=1, aborted=1 after 255 idle cycles. With activity every 100 cycles: no timeout.
